// File: rtl/regfile_wport_arbiter.sv
// Shares the RegFile write port between writeback (always wins) and a queued aux requester.
// Optional forwarding outputs are enabled by defining REGFILE_ARB_FWD_EN.
module regfile_wport_arbiter #(
    parameter int unsigned DEPTH        = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_we,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    input  logic        aux_valid,
    output logic        aux_ready,
    input  logic [4:0]  aux_addr,
    input  logic [31:0] aux_data,
    output logic        rf_we,
    output logic [4:0]  rf_wa,
    output logic [31:0] rf_wd,
    input  logic [4:0]  chk_addr1,
    input  logic [4:0]  chk_addr2,
    output logic        busy1,
    output logic        busy2,
`ifdef REGFILE_ARB_FWD_EN
    output logic        fwd1_hit,
    output logic        fwd2_hit,
    output logic [31:0] fwd1_data,
    output logic [31:0] fwd2_data,
`endif
    output logic        stall_req
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    logic [4:0]       addr_q [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [SW-1:0]    starve_q, starve_d;
    logic             stall_q;

    logic wb_act, full, empty, aux_acc, aux_live, pop, bypass, push, head_ok;

    assign wb_act    = wb_we && (wb_addr != '0);
    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign aux_ready = !full;
    assign aux_acc   = aux_valid && !full;
    assign aux_live  = aux_acc && (aux_addr != '0);
    assign pop       = !wb_act && !empty;
    assign bypass    = !wb_act && empty && aux_live;
    assign push      = aux_live && !bypass;
    assign head_ok   = valid_q[rd_ptr_q];
    assign stall_req = stall_q;

    // An invalidated head still consumes the port cycle; the next entry waits a cycle.
    always_comb begin
        rf_we = 1'b0;
        rf_wa = '0;
        rf_wd = '0;
        if (!rst) begin
            if (wb_act) begin
                rf_we = 1'b1;
                rf_wa = wb_addr;
                rf_wd = wb_data;
            end else if (pop && head_ok) begin
                rf_we = 1'b1;
                rf_wa = addr_q[rd_ptr_q];
                rf_wd = data_q[rd_ptr_q];
            end else if (bypass) begin
                rf_we = 1'b1;
                rf_wa = aux_addr;
                rf_wd = aux_data;
            end
        end
    end

    // WAW kill first, then the younger aux enqueue may set its own slot valid.
    always_comb begin
        valid_d = valid_q;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (wb_act && (addr_q[i] == wb_addr)) valid_d[i] = 1'b0;
        end
        if (pop)  valid_d[rd_ptr_q] = 1'b0;
        if (push) valid_d[wr_ptr_q] = 1'b1;

        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);

        if (empty || pop)
            starve_d = '0;
        else if (head_ok && (starve_q != SW'(STARVE_LIMIT)))
            starve_d = starve_q + SW'(1);
        else
            starve_d = starve_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            starve_q <= '0;
            stall_q  <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            stall_q  <= (starve_d == SW'(STARVE_LIMIT));
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr_q] <= aux_addr;
            data_q[wr_ptr_q] <= aux_data;
        end
    end

    // Scan oldest to youngest so the last match is the youngest entry.
    logic [PW-1:0] idx;
    logic [31:0]   hit1_data, hit2_data;
    always_comb begin
        busy1     = 1'b0;
        busy2     = 1'b0;
        hit1_data = '0;
        hit2_data = '0;
        idx       = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            idx = rd_ptr_q + PW'(k);
            if (valid_q[idx] && (chk_addr1 != '0) && (addr_q[idx] == chk_addr1)) begin
                busy1     = 1'b1;
                hit1_data = data_q[idx];
            end
            if (valid_q[idx] && (chk_addr2 != '0) && (addr_q[idx] == chk_addr2)) begin
                busy2     = 1'b1;
                hit2_data = data_q[idx];
            end
        end
    end

`ifdef REGFILE_ARB_FWD_EN
    assign fwd1_hit  = busy1;
    assign fwd2_hit  = busy2;
    assign fwd1_data = hit1_data;
    assign fwd2_data = hit2_data;
`else
    logic unused_hit;
    assign unused_hit = ^{hit1_data, hit2_data};
`endif

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Directed bench for regfile_wport_arbiter with a small RegFile model on the write port.
module tb_regfile_wport_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        aux_valid;
    logic        aux_ready;
    logic [4:0]  aux_addr;
    logic [31:0] aux_data;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;
    logic [4:0]  chk_addr1, chk_addr2;
    logic        busy1, busy2;
    logic        stall_req;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    regfile_wport_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .aux_valid(aux_valid), .aux_ready(aux_ready), .aux_addr(aux_addr), .aux_data(aux_data),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
        .chk_addr1(chk_addr1), .chk_addr2(chk_addr2),
        .busy1(busy1), .busy2(busy2),
        .stall_req(stall_req)
    );

    // RegFile model: r0 reads zero, cleared only by the bench at start.
    logic [31:0] mem [32];
    logic        mdl_clr;
    logic [31:0] rd1, rd2;
    always @(posedge clk) begin
        if (mdl_clr) begin
            for (int i = 0; i < 32; i++) mem[i] <= '0;
        end else if (rf_we && rf_wa != 5'd0) begin
            mem[rf_wa] <= rf_wd;
        end
    end
    assign rd1 = (chk_addr1 == 5'd0) ? 32'd0 : mem[chk_addr1];
    assign rd2 = (chk_addr2 == 5'd0) ? 32'd0 : mem[chk_addr2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic av, input logic [4:0] aa, input logic [31:0] ad);
        wb_we = we; wb_addr = wa; wb_data = wd;
        aux_valid = av; aux_addr = aa; aux_data = ad;
    endtask

    initial begin
        rst = 1'b1; mdl_clr = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        chk_addr1 = 5'd0; chk_addr2 = 5'd0;
        tick(); tick();
        @(negedge clk);
        chk("rst_rf_we", rf_we, 0);
        chk("rst_aux_ready", aux_ready, 1);
        chk("rst_stall", stall_req, 0);
        chk("rst_busy1", busy1, 0);
        tick();
        rst = 1'b0; mdl_clr = 1'b0;

        // Bypass into an empty FIFO
        drive(0, 0, 0, 1, 5'd5, 32'hDEADBEEF);
        chk_addr1 = 5'd5;
        @(negedge clk);
        chk("byp_we", rf_we, 1);
        chk("byp_wa", rf_wa, 5);
        chk("byp_wd", rf_wd, 32'hDEADBEEF);
        chk("byp_busy", busy1, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("byp_rd1", rd1, 32'hDEADBEEF);
        chk("byp_idle", rf_we, 0);
        tick();

        // Queue behind writeback, then drain in order
        drive(1, 5'd1, 32'h1, 1, 5'd7, 32'h11);
        chk_addr1 = 5'd7; chk_addr2 = 5'd8;
        @(negedge clk);
        chk("q1_wa", rf_wa, 1);
        chk("q1_ready", aux_ready, 1);
        tick();
        drive(1, 5'd2, 32'h2, 1, 5'd8, 32'h22);
        @(negedge clk);
        chk("q2_wa", rf_wa, 2);
        chk("q2_busy1", busy1, 1);
        chk("q2_busy2", busy2, 0);
        tick();
        drive(1, 5'd3, 32'h3, 0, 0, 0);
        @(negedge clk);
        chk("q3_ready_full", aux_ready, 0);
        chk("q3_busy1", busy1, 1);
        chk("q3_busy2", busy2, 1);
        chk("q3_wd", rf_wd, 32'h3);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("d1_we", rf_we, 1);
        chk("d1_wa", rf_wa, 7);
        chk("d1_wd", rf_wd, 32'h11);
        tick();
        @(negedge clk);
        chk("d2_wa", rf_wa, 8);
        chk("d2_wd", rf_wd, 32'h22);
        chk("d2_busy1", busy1, 0);
        chk("d2_busy2", busy2, 1);
        tick();
        @(negedge clk);
        chk("d3_idle", rf_we, 0);
        chk("d3_busy2", busy2, 0);
        chk("d3_rd1", rd1, 32'h11);
        chk("d3_rd2", rd2, 32'h22);
        tick();

        // WAW kill of a queued entry
        drive(1, 5'd1, 32'h5, 1, 5'd9, 32'hAA);
        chk_addr1 = 5'd9; chk_addr2 = 5'd0;
        tick();
        drive(1, 5'd9, 32'hBB, 0, 0, 0);
        @(negedge clk);
        chk("waw_busy_before", busy1, 1);
        chk("waw_wd", rf_wd, 32'hBB);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("waw_busy_after", busy1, 0);
        chk("waw_silent_pop", rf_we, 0);
        tick();
        @(negedge clk);
        chk("waw_rd1", rd1, 32'hBB);
        chk("waw_empty", rf_we, 0);
        tick();

        // Starvation and saturation
        drive(1, 5'd1, 32'h6, 1, 5'd12, 32'h55);
        chk_addr1 = 5'd12;
        tick();
        drive(1, 5'd2, 32'h7, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("starve_stall", stall_req, (i == 4) ? 1 : 0);
            tick();
        end
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("starve_sat", stall_req, 1);
        chk("starve_pop_wa", rf_wa, 12);
        chk("starve_pop_wd", rf_wd, 32'h55);
        tick();
        @(negedge clk);
        chk("starve_clear", stall_req, 0);
        chk("starve_rd1", rd1, 32'h55);
        tick();

        // r0 writes from both sources are dropped
        drive(1, 5'd0, 32'h999, 1, 5'd0, 32'h1234);
        chk_addr1 = 5'd0;
        @(negedge clk);
        chk("r0_we", rf_we, 0);
        chk("r0_ready", aux_ready, 1);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("r0_noenq", rf_we, 0);
        chk("r0_busy", busy1, 0);
        chk("r0_rd1", rd1, 0);
        tick();

        // Reset while two entries are queued
        drive(1, 5'd1, 32'h8, 1, 5'd20, 32'h1);
        chk_addr1 = 5'd20; chk_addr2 = 5'd21;
        tick();
        drive(1, 5'd2, 32'h9, 1, 5'd21, 32'h2);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        #1;
        chk("prerst_busy1", busy1, 1);
        chk("prerst_ready", aux_ready, 0);
        chk("prerst_we", rf_we, 1);
        rst = 1'b1;
        #1;
        chk("midrst_we", rf_we, 0);
        chk("midrst_ready", aux_ready, 1);
        chk("midrst_busy1", busy1, 0);
        chk("midrst_busy2", busy2, 0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("postrst_we", rf_we, 0);
        chk("postrst_rd1", rd1, 0);
        chk("postrst_rd2", rd2, 0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
